replay_ring_buf: RTL and testbench
==================================

// Module: replay_ring_buf
// PURPOSE
//  Parametrised ring buffer that pulls a batch of up to DEPTH words from an upstream FIFO, then
//  replays that batch to a valid/ready client as many times as required. The client releases the
//  batch (NEXT) or MAX_PASSES auto-releases it, and the block refills; DONE when upstream is exhausted.
//  Sits between the candidate/keystream FIFO and the crypto1 search/compare engines.
// PARAMETERS
//  WIDTH       32  data word width (bits)
//  DEPTH       16  max batch size in words; >=2, power of two
//  PASS_W      8   width of PASS_CNT; saturates at all-ones
//  MAX_PASSES  0   0 = replay until NEXT; N>0 = auto-release after N complete passes
// PORTS
//  CLK          in   1                 clock
//  RESETn       in   1                 synchronous active-low reset
//  FIFO_RDDATA  in   WIDTH             upstream read data, valid 1 cycle after FIFO_RDEN
//  FIFO_RDEN    out  1                 upstream read strobe
//  FIFO_RDEMPTY in   1                 upstream empty
//  FIFO_DONE    in   1                 upstream will produce no further words
//  OUT_DATA     out  WIDTH             current replay word = mem[ridx]
//  OUT_VALID    out  1                 OUT_DATA valid (REPLAY state)
//  OUT_READY    in   1                 client accepts OUT_DATA
//  OUT_LAST     out  1                 OUT_DATA is last word of batch (ridx==COUNT-1)
//  NEXT         in   1                 release current batch, start refill
//  REWIND       in   1                 restart current pass at word 0
//  COUNT        out  $clog2(DEPTH)+1   words held in current batch
//  PASS_CNT     out  PASS_W            completed passes over current batch
//  FULL         out  1                 COUNT==DEPTH
//  DONE         out  1                 upstream exhausted, no batch pending (sticky)
// BEHAVIOUR
//  - Reset: state FILL, COUNT=0, ridx=0, PASS_CNT=0, in-flight flag=0; all outputs 0. Reset
//    mid-operation discards the buffered batch and any in-flight FIFO word.
//  - States: FILL -> REPLAY -> (FILL | FINISHED). FINISHED is terminal until reset.
//  - FILL: FIFO_RDEN = ~FIFO_RDEMPTY & (COUNT + inflight < DEPTH). Word returned 1 cycle later is
//    written at mem[COUNT]; COUNT++. Never more than one outstanding read.
//    -> REPLAY when COUNT reaches DEPTH, or when FIFO_DONE & FIFO_RDEMPTY & ~inflight & COUNT>0.
//    -> FINISHED when FIFO_DONE & FIFO_RDEMPTY & ~inflight & COUNT==0.
//    OUT_VALID=0; NEXT/REWIND/OUT_READY ignored.
//  - REPLAY: FIFO_RDEN=0, OUT_VALID=1, OUT_DATA combinational from mem[ridx].
//    Transfer = OUT_VALID & OUT_READY: ridx++; on OUT_LAST, ridx wraps to 0 and PASS_CNT++ (saturating).
//    Priority per cycle: NEXT > auto-release > REWIND > transfer increment.
//    NEXT: next cycle COUNT=0, ridx=0, PASS_CNT=0, state FILL; a same-cycle transfer counts as consumed.
//    Auto-release (MAX_PASSES>0): transfer with OUT_LAST when PASS_CNT==MAX_PASSES-1 behaves as NEXT.
//    REWIND: ridx=0 next cycle; PASS_CNT unchanged; same-cycle transfer consumed but not advanced.
//  - FINISHED: DONE=1, FIFO_RDEN=0, OUT_VALID=0; all inputs ignored.
//  - Single-word batch: OUT_LAST held 1; each transfer increments PASS_CNT.
//  - ridx/COUNT compare uses $clog2(DEPTH)+1 bits; mem index uses low $clog2(DEPTH) bits.
// STRUCTURE
//  - Package crypto1_ringbuf_pkg: rb_state_e {RB_FILL, RB_REPLAY, RB_FINISHED}.
//  - Sub-module ring_mem (WIDTH, DEPTH): 1 sync write port, 1 async read port, no reset on storage.
//  - Top holds FSM, inflight flag, COUNT/ridx/PASS_CNT counters.
// TESTING (WIDTH=8, DEPTH=4, MAX_PASSES=0 unless noted)
//  1 Push 0xA0..0xA3, OUT_READY=1 -> FULL=1, COUNT=4; OUT_DATA A0,A1,A2,A3(LAST),A0..; PASS_CNT=2 after 8 xfers.
//  2 Push 0x11,0x22 then FIFO_DONE, empty -> REPLAY COUNT=2, OUT_LAST on 0x22; NEXT -> FIFO_DONE&empty -> DONE=1.
//  3 MAX_PASSES=2, push 4 words then 0xB0.. -> after 8 xfers auto-refill; next OUT_DATA=0xB0, PASS_CNT=0.
//  4 REWIND after xfers A0,A1 with OUT_READY held -> next OUT_DATA=A0; NEXT+REWIND same cycle -> FILL, COUNT=0.
//  5 FIFO_RDEMPTY toggling each cycle during fill -> no duplicate/lost words, FIFO_RDEN never with inflight at COUNT=3.
//  6 RESETn low for 1 cycle mid-REPLAY and mid-FILL -> COUNT=0, OUT_VALID=0, FIFO_RDEN=0 during reset, refills cleanly.

Source files
------------

// File: rtl/crypto1_ringbuf_pkg.sv
// Shared types for the replay ring buffer that feeds the crypto1 search/compare engines.
package crypto1_ringbuf_pkg;

    // Controller phases: gather a batch, replay it, or stop once upstream has run dry.
    typedef enum logic [1:0] {
        RB_FILL     = 2'd0,
        RB_REPLAY   = 2'd1,
        RB_FINISHED = 2'd2
    } rb_state_e;

endpackage

// File: rtl/ring_mem.sv
// Batch storage: one synchronous write port used while filling, one asynchronous
// read port so the replay word is available in the same cycle as its index.
module ring_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     CLK,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Capture the returning upstream word at its slot.
    // NOTE: storage has no reset on purpose; COUNT gates which entries are meaningful, and
    // a resettable array would turn a compact RAM into a bank of individually reset flops.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/replay_ring_buf.sv
// Replay ring buffer: pulls up to DEPTH words from an upstream FIFO, then replays that batch
// to a valid/ready client until the client releases it (NEXT) or MAX_PASSES passes complete.
module replay_ring_buf
    import crypto1_ringbuf_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 16,
    parameter int PASS_W     = 8,
    parameter int MAX_PASSES = 0
) (
    input  logic                   CLK,
    input  logic                   RESETn,
    input  logic [WIDTH-1:0]       FIFO_RDDATA,
    output logic                   FIFO_RDEN,
    input  logic                   FIFO_RDEMPTY,
    input  logic                   FIFO_DONE,
    output logic [WIDTH-1:0]       OUT_DATA,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic                   OUT_LAST,
    input  logic                   NEXT,
    input  logic                   REWIND,
    output logic [$clog2(DEPTH):0] COUNT,
    output logic [PASS_W-1:0]      PASS_CNT,
    output logic                   FULL,
    output logic                   DONE
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Counters carry one extra bit so a full batch (COUNT==DEPTH) is representable.
    localparam logic [CW-1:0]     DEPTH_C   = CW'(DEPTH);
    localparam logic [PASS_W-1:0] PASS_SAT  = '1;
    localparam bit                AUTO_EN   = (MAX_PASSES > 0);
    localparam logic [PASS_W-1:0] AUTO_LAST = AUTO_EN ? PASS_W'(MAX_PASSES - 1) : '0;

    rb_state_e         state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     ridx_q, ridx_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic              inflight_q, inflight_d;

    logic              rden_s;
    logic              valid_s;
    logic              done_s;
    logic              last_s;
    logic              xfer_s;
    logic              upstream_dry_s;
    logic              release_s;
    logic              mem_wr_s;
    logic [CW-1:0]     occupancy_s;
    logic [WIDTH-1:0]  rd_word_s;

    // Words already held plus the one read still on its way back.
    assign occupancy_s    = count_q + {{(CW-1){1'b0}}, inflight_q};
    assign upstream_dry_s = FIFO_DONE & FIFO_RDEMPTY & ~inflight_q;
    assign last_s         = (ridx_q == (count_q - CW'(1)));
    assign xfer_s         = valid_s & OUT_READY;
    // Releasing the batch: explicit NEXT, or the last word of the final allowed pass.
    assign release_s      = valid_s &
                            (NEXT | (AUTO_EN & xfer_s & last_s & (pass_q == AUTO_LAST)));

    // State and counter registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples the
    // pre-edge value of every other flop regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q    <= RB_FILL;
            count_q    <= '0;
            ridx_q     <= '0;
            pass_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            ridx_q     <= ridx_d;
            pass_q     <= pass_d;
            inflight_q <= inflight_d;
        end
    end

    // Next-state selection for the fill/replay/finished controller.
    // NOTE: every output of a combinational block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RB_FILL: begin
                if (count_q == DEPTH_C) begin
                    state_d = RB_REPLAY;
                end else if (upstream_dry_s) begin
                    state_d = (count_q != '0) ? RB_REPLAY : RB_FINISHED;
                end
            end
            RB_REPLAY: begin
                if (release_s) begin
                    state_d = RB_FILL;
                end
            end
            RB_FINISHED: begin
                state_d = RB_FINISHED;
            end
            default: begin
                state_d = RB_FILL;
            end
        endcase
    end

    // Per-state strobes: upstream read request, replay valid, terminal flag.
    always_comb begin
        rden_s  = 1'b0;
        valid_s = 1'b0;
        done_s  = 1'b0;
        unique case (state_q)
            RB_FILL:     rden_s  = ~FIFO_RDEMPTY & (occupancy_s < DEPTH_C);
            RB_REPLAY:   valid_s = 1'b1;
            RB_FINISHED: done_s  = 1'b1;
            default:     ;
        endcase
    end

    // Counter updates: capture returning words while filling, walk the batch while replaying.
    always_comb begin
        count_d    = count_q;
        ridx_d     = ridx_q;
        pass_d     = pass_q;
        inflight_d = 1'b0;
        mem_wr_s   = 1'b0;
        unique case (state_q)
            RB_FILL: begin
                // At most one read outstanding: the request condition already counts it.
                inflight_d = rden_s;
                if (inflight_q) begin
                    mem_wr_s = 1'b1;
                    count_d  = count_q + CW'(1);
                end
            end
            RB_REPLAY: begin
                if (release_s) begin
                    count_d = '0;
                    ridx_d  = '0;
                    pass_d  = '0;
                end else if (REWIND) begin
                    // A same-cycle transfer is consumed but the pass does not advance.
                    ridx_d = '0;
                end else if (xfer_s) begin
                    if (last_s) begin
                        ridx_d = '0;
                        if (pass_q != PASS_SAT) begin
                            pass_d = pass_q + PASS_W'(1);
                        end
                    end else begin
                        ridx_d = ridx_q + CW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    ring_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .CLK     (CLK),
        .wr_en   (mem_wr_s),
        .wr_addr (count_q[AW-1:0]),
        .wr_data (FIFO_RDDATA),
        .rd_addr (ridx_q[AW-1:0]),
        .rd_data (rd_word_s)
    );

    // Strobes are forced low while reset is held so nothing is requested or presented.
    assign FIFO_RDEN = RESETn & rden_s;
    assign OUT_VALID = RESETn & valid_s;
    assign OUT_LAST  = RESETn & valid_s & last_s;
    assign DONE      = RESETn & done_s;
    assign OUT_DATA  = rd_word_s;
    assign COUNT     = count_q;
    assign PASS_CNT  = pass_q;
    assign FULL      = (count_q == DEPTH_C);

endmodule

// File: tb/tb_replay_ring_buf.sv
// Bench for replay_ring_buf: two instances (manual release, and auto-release after two passes)
// fed by a behavioural upstream FIFO and checked against a batch/index/pass reference model.
module tb_replay_ring_buf;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Per-instance signals: index 0 is MAX_PASSES=0, index 1 is MAX_PASSES=2.
    logic       rst_n     [2];
    logic [7:0] rddata    [2];
    logic       rden      [2];
    logic       empty     [2];
    logic       fdone     [2];
    logic [7:0] out_data  [2];
    logic       out_valid [2];
    logic       out_ready [2];
    logic       out_last  [2];
    logic       nxt       [2];
    logic       rew       [2];
    logic [2:0] count     [2];
    logic [7:0] pass_cnt  [2];
    logic       full      [2];
    logic       done      [2];

    replay_ring_buf #(.WIDTH(8), .DEPTH(4), .PASS_W(8), .MAX_PASSES(0)) dut0 (
        .CLK(clk), .RESETn(rst_n[0]), .FIFO_RDDATA(rddata[0]), .FIFO_RDEN(rden[0]),
        .FIFO_RDEMPTY(empty[0]), .FIFO_DONE(fdone[0]), .OUT_DATA(out_data[0]),
        .OUT_VALID(out_valid[0]), .OUT_READY(out_ready[0]), .OUT_LAST(out_last[0]),
        .NEXT(nxt[0]), .REWIND(rew[0]), .COUNT(count[0]), .PASS_CNT(pass_cnt[0]),
        .FULL(full[0]), .DONE(done[0])
    );

    replay_ring_buf #(.WIDTH(8), .DEPTH(4), .PASS_W(8), .MAX_PASSES(2)) dut1 (
        .CLK(clk), .RESETn(rst_n[1]), .FIFO_RDDATA(rddata[1]), .FIFO_RDEN(rden[1]),
        .FIFO_RDEMPTY(empty[1]), .FIFO_DONE(fdone[1]), .OUT_DATA(out_data[1]),
        .OUT_VALID(out_valid[1]), .OUT_READY(out_ready[1]), .OUT_LAST(out_last[1]),
        .NEXT(nxt[1]), .REWIND(rew[1]), .COUNT(count[1]), .PASS_CNT(pass_cnt[1]),
        .FULL(full[1]), .DONE(done[1])
    );

    // Upstream FIFO model: a word list per instance with a read pointer.
    logic [7:0] src [2][256];
    int         src_len [2];
    int         src_rd  [2];
    bit         hold_empty [2];
    bit         prev_rden  [2];
    bit         bad_rd     [2];

    assign empty[0] = (src_rd[0] >= src_len[0]) || hold_empty[0];
    assign empty[1] = (src_rd[1] >= src_len[1]) || hold_empty[1];

    // Serve reads one cycle later; remember whether a read was made while empty.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            prev_rden[i] <= rden[i];
            if (rden[i]) begin
                if (empty[i]) begin
                    bad_rd[i] <= 1'b1;
                end else begin
                    rddata[i] <= src[i][src_rd[i]];
                    src_rd[i] <= src_rd[i] + 1;
                end
            end
        end
    end

    // Reference model: batch = src[base .. base+n-1], replay index, completed passes.
    int cons_ptr [2];
    int m_base   [2];
    int m_n      [2];
    int m_idx    [2];
    int m_pass   [2];
    bit m_rel    [2];

    int checks   = 0;
    int failures = 0;

    task automatic push(input int sel, input logic [7:0] v);
        src[sel][src_len[sel]] = v;
        src_len[sel] = src_len[sel] + 1;
    endtask

    // Wait (bounded) for the batch to appear; optionally toggle upstream empty while filling.
    task automatic wait_replay(input int sel, input int exp_n, input bit toggle);
        int cyc = 0;
        @(negedge clk);
        while (out_valid[sel] !== 1'b1 && cyc < 60) begin
            if (toggle) hold_empty[sel] = ~hold_empty[sel];
            #1;
            checks++;
            if (rden[sel] === 1'b1 && (int'(count[sel]) + int'(prev_rden[sel])) >= 4) begin
                failures++;
                $display("FAIL fill_read_bound dut%0d: rden=1 with count=%0d inflight=%0d, want rden=0",
                         sel, count[sel], prev_rden[sel]);
            end
            cyc++;
            @(negedge clk);
        end
        hold_empty[sel] = 1'b0;
        checks++;
        if (out_valid[sel] !== 1'b1) begin
            failures++;
            $display("FAIL fill_timeout dut%0d: out_valid=%b after %0d cycles, want 1", sel, out_valid[sel], cyc);
        end
        checks++;
        if (count[sel] !== 3'(exp_n)) begin
            failures++;
            $display("FAIL batch_count dut%0d: got %0d want %0d", sel, count[sel], exp_n);
        end
        checks++;
        if (full[sel] !== (exp_n == 4)) begin
            failures++;
            $display("FAIL batch_full dut%0d: got %b want %b", sel, full[sel], exp_n == 4);
        end
        m_base[sel]   = cons_ptr[sel];
        cons_ptr[sel] = cons_ptr[sel] + exp_n;
        m_n[sel]      = exp_n;
        m_idx[sel]    = 0;
        m_pass[sel]   = 0;
        m_rel[sel]    = 1'b0;
    endtask

    // One replay cycle: compare against the model, drive the client inputs, advance the model.
    task automatic step(input int sel, input bit rdy, input bit rwd, input bit nx);
        logic [7:0] exp_d;
        bit         exp_last;
        int         maxp;
        @(negedge clk);
        exp_d    = src[sel][m_base[sel] + m_idx[sel]];
        exp_last = (m_idx[sel] == m_n[sel] - 1);
        checks++;
        if (out_valid[sel] !== 1'b1) begin
            failures++;
            $display("FAIL replay_valid dut%0d: got %b want 1", sel, out_valid[sel]);
        end
        checks++;
        if (out_data[sel] !== exp_d) begin
            failures++;
            $display("FAIL replay_data dut%0d idx%0d: got %h want %h", sel, m_idx[sel], out_data[sel], exp_d);
        end
        checks++;
        if (out_last[sel] !== exp_last) begin
            failures++;
            $display("FAIL replay_last dut%0d idx%0d: got %b want %b", sel, m_idx[sel], out_last[sel], exp_last);
        end
        checks++;
        if (pass_cnt[sel] !== 8'(m_pass[sel])) begin
            failures++;
            $display("FAIL pass_cnt dut%0d: got %0d want %0d", sel, pass_cnt[sel], m_pass[sel]);
        end
        checks++;
        if (count[sel] !== 3'(m_n[sel])) begin
            failures++;
            $display("FAIL replay_count dut%0d: got %0d want %0d", sel, count[sel], m_n[sel]);
        end
        out_ready[sel] = rdy;
        rew[sel]       = rwd;
        nxt[sel]       = nx;
        maxp = (sel == 1) ? 2 : 0;
        if (nx) begin
            m_rel[sel] = 1'b1;
        end else if (maxp > 0 && rdy && exp_last && m_pass[sel] == maxp - 1) begin
            m_rel[sel] = 1'b1;
        end else if (rwd) begin
            m_idx[sel] = 0;
        end else if (rdy) begin
            if (exp_last) begin
                m_idx[sel] = 0;
                if (m_pass[sel] < 255) m_pass[sel] = m_pass[sel] + 1;
            end else begin
                m_idx[sel] = m_idx[sel] + 1;
            end
        end
    endtask

    // The cycle after a release: back to filling with an empty batch.
    task automatic post_release(input int sel);
        @(negedge clk);
        out_ready[sel] = 1'b0;
        rew[sel]       = 1'b0;
        nxt[sel]       = 1'b0;
        checks++;
        if (out_valid[sel] !== 1'b0) begin
            failures++;
            $display("FAIL release_valid dut%0d: got %b want 0", sel, out_valid[sel]);
        end
        checks++;
        if (count[sel] !== 3'd0) begin
            failures++;
            $display("FAIL release_count dut%0d: got %0d want 0", sel, count[sel]);
        end
        checks++;
        if (pass_cnt[sel] !== 8'd0) begin
            failures++;
            $display("FAIL release_pass dut%0d: got %0d want 0", sel, pass_cnt[sel]);
        end
    endtask

    // One-cycle reset; caller is just after a falling edge.
    task automatic do_reset(input int sel);
        rst_n[sel]      = 1'b0;
        out_ready[sel]  = 1'b0;
        rew[sel]        = 1'b0;
        nxt[sel]        = 1'b0;
        hold_empty[sel] = 1'b0;
        #1;
        checks++;
        if (rden[sel] !== 1'b0 || out_valid[sel] !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobes dut%0d: rden=%b valid=%b want 0 0", sel, rden[sel], out_valid[sel]);
        end
        @(negedge clk);
        checks++;
        if (count[sel] !== 3'd0 || pass_cnt[sel] !== 8'd0) begin
            failures++;
            $display("FAIL reset_counters dut%0d: count=%0d pass=%0d want 0 0", sel, count[sel], pass_cnt[sel]);
        end
        checks++;
        if (out_valid[sel] !== 1'b0 || rden[sel] !== 1'b0 || done[sel] !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs dut%0d: valid=%b rden=%b done=%b want 0 0 0",
                     sel, out_valid[sel], rden[sel], done[sel]);
        end
        rst_n[sel]    = 1'b1;
        cons_ptr[sel] = src_rd[sel];
    endtask

    // Bounded wait for DONE, then confirm it is sticky and inputs are ignored.
    task automatic wait_done(input int sel);
        int cyc = 0;
        @(negedge clk);
        while (done[sel] !== 1'b1 && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (done[sel] !== 1'b1) begin
            failures++;
            $display("FAIL done_timeout dut%0d: done=%b want 1", sel, done[sel]);
        end
        for (int i = 0; i < 4; i++) begin
            out_ready[sel] = 1'($urandom_range(0, 1));
            nxt[sel]       = 1'($urandom_range(0, 1));
            rew[sel]       = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (done[sel] !== 1'b1 || out_valid[sel] !== 1'b0 || rden[sel] !== 1'b0 || count[sel] !== 3'd0) begin
                failures++;
                $display("FAIL done_sticky dut%0d: done=%b valid=%b rden=%b count=%0d want 1 0 0 0",
                         sel, done[sel], out_valid[sel], rden[sel], count[sel]);
            end
        end
        out_ready[sel] = 1'b0;
        nxt[sel]       = 1'b0;
        rew[sel]       = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (rden[s] !== 1'b0 || out_valid[s] !== 1'b0 || out_last[s] !== 1'b0 || done[s] !== 1'b0) begin
                failures++;
                $display("FAIL reset_strobes_init dut%0d: rden=%b valid=%b last=%b done=%b want 0",
                         s, rden[s], out_valid[s], out_last[s], done[s]);
            end
            checks++;
            if (count[s] !== 3'd0 || pass_cnt[s] !== 8'd0 || full[s] !== 1'b0) begin
                failures++;
                $display("FAIL reset_state_init dut%0d: count=%0d pass=%0d full=%b want 0",
                         s, count[s], pass_cnt[s], full[s]);
            end
            rst_n[s] = 1'b1;
        end
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (out_valid[s] !== 1'b0 || rden[s] !== 1'b0 || done[s] !== 1'b0) begin
                failures++;
                $display("FAIL idle_after_reset dut%0d: valid=%b rden=%b done=%b want 0 0 0",
                         s, out_valid[s], rden[s], done[s]);
            end
        end
    endtask

    task automatic test_full_batch();
        for (int i = 0; i < 4; i++) push(0, 8'hA0 + 8'(i));
        wait_replay(0, 4, 1'b0);
        for (int i = 0; i < 8; i++) step(0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        out_ready[0] = 1'b0;
        checks++;
        if (pass_cnt[0] !== 8'd2 || out_data[0] !== 8'hA0) begin
            failures++;
            $display("FAIL two_passes: pass=%0d data=%h want 2 a0", pass_cnt[0], out_data[0]);
        end
        step(0, 1'b0, 1'b0, 1'b1);
        post_release(0);
    endtask

    task automatic test_rewind();
        for (int i = 0; i < 4; i++) push(0, 8'hC0 + 8'(i));
        wait_replay(0, 4, 1'b0);
        step(0, 1'b1, 1'b0, 1'b0);
        step(0, 1'b1, 1'b0, 1'b0);
        step(0, 1'b1, 1'b1, 1'b0);
        step(0, 1'b0, 1'b0, 1'b0);
        step(0, 1'b1, 1'b0, 1'b0);
        step(0, 1'b1, 1'b1, 1'b1);
        post_release(0);
    endtask

    task automatic test_empty_toggle();
        for (int i = 0; i < 4; i++) push(0, 8'($urandom));
        wait_replay(0, 4, 1'b1);
        for (int i = 0; i < 4; i++) step(0, 1'b1, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 1'b1);
        post_release(0);
    endtask

    task automatic test_random_batches();
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 4; i++) push(0, 8'($urandom));
            wait_replay(0, 4, 1'($urandom_range(0, 1)));
            for (int c = 0; c < 40 && !m_rel[0]; c++) begin
                step(0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
                     c >= 20 && $urandom_range(0, 7) == 0);
            end
            if (!m_rel[0]) step(0, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
            post_release(0);
        end
    endtask

    task automatic test_auto_release();
        for (int i = 0; i < 4; i++) push(1, 8'hD0 + 8'(i));
        for (int i = 0; i < 4; i++) push(1, 8'hB0 + 8'(i));
        wait_replay(1, 4, 1'b0);
        for (int i = 0; i < 8; i++) step(1, 1'b1, 1'b0, 1'b0);
        post_release(1);
        wait_replay(1, 4, 1'b0);
        for (int c = 0; c < 300 && !m_rel[1]; c++) begin
            step(1, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, 1'b0);
        end
        if (!m_rel[1]) step(1, 1'b0, 1'b0, 1'b1);
        post_release(1);
    endtask

    task automatic test_reset_mid();
        int start;
        int cyc;
        // Reset while replaying a full batch.
        for (int i = 0; i < 4; i++) push(0, 8'($urandom));
        wait_replay(0, 4, 1'b0);
        step(0, 1'b1, 1'b0, 1'b0);
        step(0, 1'b1, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        do_reset(0);
        for (int i = 0; i < 4; i++) push(0, 8'($urandom));
        wait_replay(0, 4, 1'b0);
        for (int i = 0; i < 4; i++) step(0, 1'b1, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 1'b1);
        post_release(0);
        // Reset while filling, with a read possibly in flight.
        start = src_rd[0];
        for (int i = 0; i < 4; i++) push(0, 8'($urandom));
        cyc = 0;
        @(negedge clk);
        while (src_rd[0] < start + 2 && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (src_rd[0] < start + 2) begin
            failures++;
            $display("FAIL fill_progress: read %0d words want 2", src_rd[0] - start);
        end
        do_reset(0);
        for (int i = 0; i < 2; i++) push(0, 8'($urandom));
        wait_replay(0, 4, 1'b0);
        for (int i = 0; i < 5; i++) step(0, 1'b1, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 1'b1);
        post_release(0);
    endtask

    task automatic test_partial_done();
        fdone[0] = 1'b1;
        push(0, 8'h11);
        push(0, 8'h22);
        wait_replay(0, 2, 1'b0);
        for (int i = 0; i < 3; i++) step(0, 1'b1, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 1'b1);
        post_release(0);
        wait_done(0);
    endtask

    task automatic test_single_word();
        push(0, 8'h5A);
        @(negedge clk);
        do_reset(0);
        wait_replay(0, 1, 1'b0);
        // Enough transfers to drive PASS_CNT into saturation.
        for (int i = 0; i < 260; i++) step(0, 1'b1, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 1'b1);
        post_release(0);
        wait_done(0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            rst_n[s]     = 1'b0;
            fdone[s]     = 1'b0;
            out_ready[s] = 1'b0;
            nxt[s]       = 1'b0;
            rew[s]       = 1'b0;
            src_len[s]   = 0;
            cons_ptr[s]  = 0;
        end
        test_reset();
        test_full_batch();
        test_rewind();
        test_empty_toggle();
        test_random_batches();
        test_auto_release();
        test_reset_mid();
        test_partial_done();
        test_single_word();
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (bad_rd[s] !== 1'b0) begin
                failures++;
                $display("FAIL read_while_empty dut%0d: got %b want 0", s, bad_rd[s]);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
